// File: rtl/i2c_slave_regif.sv
// i2c_slave_regif: I2C target for a register-configuration master.
// Decodes START/STOP, matches a 7-bit device address, ACKs each byte, keeps an
// auto-incrementing 8-bit register pointer, emits write strobes and serves reads.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sioc            I2C clock input
//   siod            I2C data, open-drain (0 or z only)
//   wr_strobe       one-clk write pulse with wr_addr / wr_data
//   rd_addr         current register pointer for the external read mux
//   rd_data         register contents at rd_addr, sampled at each read byte start
//   busy            high from an address-matched START until STOP
module i2c_slave_regif #(
  parameter logic [6:0]  DEV_ADDR   = 7'h39,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  inout  tri logic   siod,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  state_t state, state_next;

  logic [1:0]            scl_sync, sda_sync;
  logic [FILTER_LEN-1:0] scl_hist, sda_hist;
  logic                  scl_f, sda_f, scl_prev, sda_prev;
  logic                  scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]            shift, ptr, byte_in;
  logic [3:0]            bit_cnt;
  logic                  ack_phase, rw, sda_low, inc_pend;

  assign siod    = sda_low ? 1'b0 : 1'bz;
  assign rd_addr = ptr;

  // Synchronizer and level filter: a new level is accepted only after
  // FILTER_LEN identical synchronized samples; otherwise the old level holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], sioc};
      sda_sync <= {sda_sync[0], siod};
      scl_hist <= {scl_hist[FILTER_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILTER_LEN-2:0], sda_sync[1]};
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;
  assign byte_in   = {shift[6:0], sda_f};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (stop_det)       state_next = IDLE;
    else if (start_det) state_next = DEV;
    else begin
      case (state)
        DEV:       if (scl_rise && bit_cnt == 4'd7)
                     state_next = (byte_in[7:1] == DEV_ADDR) ? DEV_ACK : IGNORE;
        DEV_ACK:   if (scl_fall && ack_phase) state_next = rw ? RDATA : REG;
        REG:       if (scl_rise && bit_cnt == 4'd7) state_next = REG_ACK;
        REG_ACK:   if (scl_fall && ack_phase) state_next = WDATA;
        WDATA:     if (scl_rise && bit_cnt == 4'd7) state_next = WDATA_ACK;
        WDATA_ACK: if (scl_fall && ack_phase) state_next = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 4'd8) state_next = RACK;
        RACK: begin
          if (scl_rise && sda_f)          state_next = IGNORE;
          else if (scl_fall && ack_phase) state_next = RDATA;
        end
        default: ;
      endcase
    end
  end

  // ack_phase: in ACK states, set once siod has been pulled low (first fall);
  // in RACK, records that the master ACKed so the next fall reloads a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift     <= '0;
      ptr       <= '0;
      bit_cnt   <= '0;
      ack_phase <= 1'b0;
      rw        <= 1'b0;
      sda_low   <= 1'b0;
      inc_pend  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (inc_pend) begin
        ptr      <= ptr + 8'd1;
        inc_pend <= 1'b0;
      end
      if (stop_det || start_det) begin
        sda_low   <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        if (stop_det) busy <= 1'b0;
      end else begin
        case (state)
          DEV, REG, WDATA: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ack_phase <= 1'b0;
              if (state == DEV) begin
                rw <= byte_in[0];
                if (byte_in[7:1] == DEV_ADDR) busy <= 1'b1;
              end else if (state == REG) begin
                ptr <= byte_in;
              end else begin
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= byte_in;
                inc_pend  <= 1'b1;
              end
            end
          end
          DEV_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_low   <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state == DEV_ACK && rw) begin
                shift   <= rd_data;
                sda_low <= ~rd_data[7];
              end else begin
                sda_low <= 1'b0;
              end
            end
          end
          RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low   <= 1'b0;
                ack_phase <= 1'b0;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_low <= ~shift[6];
              end
            end
          end
          RACK: begin
            if (scl_rise && !sda_f) begin
              ptr       <= ptr + 8'd1;
              ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              shift     <= rd_data;
              sda_low   <= ~rd_data[7];
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
// tb_i2c_slave_regif: directed I2C master stimulus against i2c_slave_regif.
module tb_i2c_slave_regif;

  localparam int Q = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda, glitch;
  wire        siod;
  logic       wr_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] strobes[$];

  always #5 clk = ~clk;

  pullup (siod);
  assign siod    = m_sda ? 1'bz : 1'b0;
  assign rd_data = (rd_addr == 8'h05) ? 8'h5A : 8'hC3;

  i2c_slave_regif #(.DEV_ADDR(7'h39), .FILTER_LEN(3)) dut (
    .clk(clk), .rst(rst), .sioc(m_scl), .siod(siod),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always @(negedge clk) if (wr_strobe) strobes.push_back({wr_addr, wr_data});

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] strobe_at(input int i);
    return (i < strobes.size()) ? strobes[i] : 16'hDEAD;
  endfunction

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; w(Q);
    m_scl = 1'b1; w(Q);
    m_sda = 1'b0; w(Q);
    m_scl = 1'b0; w(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; w(Q);
    m_scl = 1'b1; w(Q);
    m_sda = 1'b1; w(Q);
  endtask

  // With glitch set, a 1-clk SCL pulse lands in the low phase and a 1-clk SDA
  // inversion in the high phase; neither must register as a bit or START/STOP.
  task automatic write_bit(input logic b);
    m_sda = b; w(10);
    m_scl = glitch; w(1);
    m_scl = 1'b0; w(9);
    m_scl = 1'b1; w(10);
    if (glitch) m_sda = ~b;
    w(1);
    m_sda = b; w(29);
    m_scl = 1'b0; w(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; w(Q);
    m_scl = 1'b1; w(Q);
    b = siod; w(Q);
    m_scl = 1'b0; w(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  logic       ack;
  logic [7:0] rd;

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; glitch = 1'b0;
    w(5);
    check("rst_strobe", {15'd0, wr_strobe}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_rd_addr", {8'd0, rd_addr}, 16'h0000);
    check("rst_wr_bus", {wr_addr, wr_data}, 16'h0000);
    check("rst_siod", {15'd0, siod}, 16'd1);
    rst = 1'b0; w(10);

    // Case 1: single register write
    strobes.delete();
    i2c_start();
    write_byte(8'h72, ack); check("c1_ack_dev", {15'd0, ack}, 16'd0);
    check("c1_busy", {15'd0, busy}, 16'd1);
    write_byte(8'h41, ack); check("c1_ack_reg", {15'd0, ack}, 16'd0);
    write_byte(8'h10, ack); check("c1_ack_dat", {15'd0, ack}, 16'd0);
    i2c_stop(); w(10);
    check("c1_nstrobe", 16'(strobes.size()), 16'd1);
    check("c1_strobe0", strobe_at(0), 16'h4110);
    check("c1_busy_stop", {15'd0, busy}, 16'd0);
    check("c1_rd_addr", {8'd0, rd_addr}, 16'h0042);

    // Case 2: wrong device address
    strobes.delete();
    i2c_start();
    write_byte(8'h74, ack); check("c2_nack", {15'd0, ack}, 16'd1);
    check("c2_busy", {15'd0, busy}, 16'd0);
    write_byte(8'h41, ack); check("c2_nack2", {15'd0, ack}, 16'd1);
    write_byte(8'h10, ack);
    i2c_stop(); w(10);
    check("c2_nstrobe", 16'(strobes.size()), 16'd0);
    check("c2_rd_addr", {8'd0, rd_addr}, 16'h0042);

    // Case 3: burst across pointer wrap
    strobes.delete();
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'hFF, ack);
    write_byte(8'hAA, ack); check("c3_ack_aa", {15'd0, ack}, 16'd0);
    write_byte(8'hBB, ack); check("c3_ack_bb", {15'd0, ack}, 16'd0);
    i2c_stop(); w(10);
    check("c3_nstrobe", 16'(strobes.size()), 16'd2);
    check("c3_strobe0", strobe_at(0), 16'hFFAA);
    check("c3_strobe1", strobe_at(1), 16'h00BB);
    check("c3_rd_addr", {8'd0, rd_addr}, 16'h0001);

    // Case 4: pointer set, repeated START, single-byte read with NACK
    strobes.delete();
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h05, ack); check("c4_ack_reg", {15'd0, ack}, 16'd0);
    i2c_start();
    write_byte(8'h73, ack); check("c4_ack_rd", {15'd0, ack}, 16'd0);
    check("c4_busy", {15'd0, busy}, 16'd1);
    read_byte(1'b1, rd);
    check("c4_rdata", {8'd0, rd}, 16'h005A);
    check("c4_rd_addr", {8'd0, rd_addr}, 16'h0005);
    i2c_stop(); w(10);
    check("c4_rd_addr_stop", {8'd0, rd_addr}, 16'h0005);
    check("c4_nstrobe", 16'(strobes.size()), 16'd0);
    check("c4_busy_stop", {15'd0, busy}, 16'd0);

    // Case 5: case 1 with 1-clk glitches on both lines
    strobes.delete();
    i2c_start();
    glitch = 1'b1;
    write_byte(8'h72, ack); check("c5_ack_dev", {15'd0, ack}, 16'd0);
    write_byte(8'h41, ack); check("c5_ack_reg", {15'd0, ack}, 16'd0);
    write_byte(8'h10, ack); check("c5_ack_dat", {15'd0, ack}, 16'd0);
    glitch = 1'b0;
    i2c_stop(); w(10);
    check("c5_nstrobe", 16'(strobes.size()), 16'd1);
    check("c5_strobe0", strobe_at(0), 16'h4110);

    // Case 6: reset after the 4th data bit, then a clean write
    strobes.delete();
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    rst = 1'b1; #1;
    check("c6_siod_rst", {15'd0, siod}, 16'd1);
    check("c6_busy_rst", {15'd0, busy}, 16'd0);
    check("c6_rd_addr_rst", {8'd0, rd_addr}, 16'h0000);
    i2c_stop();
    rst = 1'b0; w(10);
    check("c6_nstrobe_abort", 16'(strobes.size()), 16'd0);
    i2c_start();
    write_byte(8'h72, ack); check("c6_ack_dev", {15'd0, ack}, 16'd0);
    write_byte(8'h22, ack);
    write_byte(8'h33, ack); check("c6_ack_dat", {15'd0, ack}, 16'd0);
    i2c_stop(); w(10);
    check("c6_nstrobe", 16'(strobes.size()), 16'd1);
    check("c6_strobe0", strobe_at(0), 16'h2233);

    // Reset while the target holds an ACK low releases siod immediately
    strobes.delete();
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(b8_72(i));
    m_sda = 1'b1; w(2);
    check("c6b_ack_low", {15'd0, siod}, 16'd0);
    rst = 1'b1; #1;
    check("c6b_siod_rst", {15'd0, siod}, 16'd1);
    w(2);
    m_scl = 1'b1; w(Q);
    rst = 1'b0; w(10);
    check("c6b_nstrobe", 16'(strobes.size()), 16'd0);
    check("c6b_busy", {15'd0, busy}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic b8_72(input int i);
    logic [7:0] v;
    v = 8'h72;
    return v[i];
  endfunction

endmodule
